maj_vote_monitor: RTL

//  Parametrised, registered N-channel majority voter with per-channel fault monitoring.
//  - Votes bitwise across NCH redundant WIDTH-bit channels.
//  - Tracks per channel how often, and for how long in a row, it disagrees with the vote.
//  - Latches a sticky fault per channel.
//  - Sits between replicated datapaths (TMR/NMR) and downstream logic that consumes the voted word.

---
 rtl/maj_vote_monitor_if.sv | 26 ++
 rtl/maj_vote_monitor.sv | 134 +++++++++++++
 2 files changed

// File: rtl/maj_vote_monitor_if.sv
// Bus bundle for the majority voter: replicated channel samples in, voted word
// plus per-channel health status out.
interface maj_vote_monitor_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 3,
  parameter int CNT_W = 8
);
  logic                   in_valid;
  logic [NCH*WIDTH-1:0]   in_data;
  logic                   clr_fault;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [NCH-1:0]         disagree;
  logic [NCH-1:0]         fault;
  logic [NCH*CNT_W-1:0]   err_cnt;

  modport master (
    output in_valid, in_data, clr_fault,
    input  out_valid, out_data, disagree, fault, err_cnt
  );

  modport slave (
    input  in_valid, in_data, clr_fault,
    output out_valid, out_data, disagree, fault, err_cnt
  );
endinterface

// File: rtl/maj_vote_monitor.sv
// Registered N-channel bitwise majority voter with per-channel mismatch
// counting, consecutive-disagreement tracking and sticky fault flags.
module maj_vote_monitor #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 3,
  parameter int FAULT_TH = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  maj_vote_monitor_if.slave bus
);

  localparam int VCW   = $clog2(NCH + 1);
  localparam int RUN_W = $clog2(FAULT_TH + 1);
  localparam logic [VCW-1:0]   MAJ_TH = VCW'((NCH + 1) / 2);
  localparam logic [RUN_W-1:0] RUN_TH = RUN_W'(FAULT_TH);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] vote_word(input logic [NCH*WIDTH-1:0] data);
    logic [VCW-1:0] ones;
    vote_word = {WIDTH{1'b0}};
    for (int b = 0; b < WIDTH; b++) begin
      ones = {VCW{1'b0}};
      for (int c = 0; c < NCH; c++) begin
        ones = ones + VCW'(data[c*WIDTH + b]);
      end
      vote_word[b] = (ones >= MAJ_TH);
    end
  endfunction

  logic [WIDTH-1:0] vote_s;
  logic [NCH-1:0]   mismatch_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  // Vote on the current sample and flag every channel that differs from it.
  always_comb begin
    vote_s     = vote_word(bus.in_data);
    mismatch_s = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      mismatch_s[c] = (bus.in_data[c*WIDTH +: WIDTH] != vote_s);
    end
  end

  // Output word register; holds its value across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        out_data_r <= vote_s;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t            state_r;
    logic [RUN_W-1:0]  run_r;
    logic [RUN_W-1:0]  run_inc_s;
    logic              fault_r;
    logic              disagree_r;
    logic [CNT_W-1:0]  err_cnt_r;

    // Saturating next value of the consecutive-mismatch run.
    always_comb begin
      if (run_r == RUN_TH) begin
        run_inc_s = run_r;
      end else begin
        run_inc_s = run_r + RUN_W'(1);
      end
    end

    // Channel health FSM; clr_fault overrides the data-driven transition.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r    <= ST_OK;
        run_r      <= {RUN_W{1'b0}};
        fault_r    <= 1'b0;
        disagree_r <= 1'b0;
        err_cnt_r  <= {CNT_W{1'b0}};
      end else begin
        if (bus.in_valid) begin
          disagree_r <= mismatch_s[c];
          if (mismatch_s[c] && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + CNT_W'(1);
          end
        end
        if (bus.clr_fault) begin
          state_r <= ST_OK;
          run_r   <= {RUN_W{1'b0}};
          fault_r <= 1'b0;
        end else if (bus.in_valid) begin
          run_r <= mismatch_s[c] ? run_inc_s : {RUN_W{1'b0}};
          case (state_r)
            ST_OK, ST_SUSPECT: begin
              if (!mismatch_s[c]) begin
                state_r <= ST_OK;
              end else if (run_inc_s == RUN_TH) begin
                state_r <= ST_FAULT;
                fault_r <= 1'b1;
              end else begin
                state_r <= ST_SUSPECT;
              end
            end
            ST_FAULT: begin
              state_r <= ST_FAULT;
              fault_r <= 1'b1;
            end
            default: begin
              state_r <= ST_OK;
              fault_r <= 1'b0;
            end
          endcase
        end
      end
    end

    assign bus.disagree[c]                = disagree_r;
    assign bus.fault[c]                   = fault_r;
    assign bus.err_cnt[c*CNT_W +: CNT_W]  = err_cnt_r;
  end

endmodule
